// File: rtl/minmax_scan.sv
// minmax_scan: streaming signed extreme-value search.
//
// A search is started from IDLE with start_i. It then consumes len_i samples
// through a valid/ready handshake and reports the largest sample
// (mode_i = 0) or the smallest sample (mode_i = 1) together with its
// zero-based position. When two samples tie, the earlier one is kept.
//
// Ports:
//   clk_i         clock; all state changes on its rising edge
//   reset_i       asynchronous, active-high reset
//   start_i       begin a search (sampled in IDLE only)
//   mode_i        0 = max, 1 = min (latched on accepted start)
//   len_i         number of samples to scan (latched on accepted start)
//   data_i        signed sample
//   data_valid_i  data_i is valid this cycle
//   data_ready_o  block accepts a sample this cycle (FIRST/SCAN)
//   result_o      selected extreme value
//   index_o       position of result_o in the sequence
//   busy_o        high from accepted start until done_o
//   done_o        single-cycle pulse when result_o/index_o are final
module minmax_scan #(
  parameter int DATA_W = 16,
  parameter int CNT_W  = 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              start_i,
  input  logic              mode_i,
  input  logic [CNT_W-1:0]  len_i,
  input  logic [DATA_W-1:0] data_i,
  input  logic              data_valid_i,
  output logic              data_ready_o,
  output logic [DATA_W-1:0] result_o,
  output logic [CNT_W-1:0]  index_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FIRST = 2'd1,
    SCAN  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic              mode_q;
  logic [CNT_W-1:0]  len_q;
  logic [CNT_W-1:0]  count_q;
  logic [DATA_W-1:0] result_q;
  logic [CNT_W-1:0]  index_q;

  logic take_start;
  logic take_empty;
  logic load_first;
  logic load_scan;

  // count_q never exceeds len_q - 1 while scanning, so the increment
  // cannot wrap even for the largest length.
  logic [CNT_W-1:0] count_inc;
  assign count_inc = count_q + CNT_W'(1);

  // Signed compare of result (r) against sample (s) without overflow:
  // form r - s as r + ~s + 1 in DATA_W+1 bits. With equal operand signs the
  // carry out is set exactly when r >= s; with differing signs the negative
  // operand is the smaller one, so the sign of r decides.
  logic [DATA_W:0] diff;
  logic            carry;
  logic            same_sign;
  logic            r_neg;
  logic            diff_zero;
  logic            r_lt_s;
  logic            r_gt_s;
  logic            replace;

  assign diff      = {1'b0, result_q} + {1'b0, ~data_i} + {{DATA_W{1'b0}}, 1'b1};
  assign carry     = diff[DATA_W];
  assign r_neg     = result_q[DATA_W-1];
  assign same_sign = (result_q[DATA_W-1] == data_i[DATA_W-1]);
  assign diff_zero = (diff[DATA_W-1:0] == '0);
  assign r_lt_s    = same_sign ? ~carry : r_neg;
  assign r_gt_s    = same_sign ? (carry & ~diff_zero) : ~r_neg;
  // Strict comparisons only, so a tie keeps the earlier sample.
  assign replace   = mode_q ? r_gt_s : r_lt_s;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt    = state;
    data_ready_o = 1'b0;
    busy_o       = 1'b0;
    done_o       = 1'b0;
    take_start   = 1'b0;
    take_empty   = 1'b0;
    load_first   = 1'b0;
    load_scan    = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          if (len_i != '0) begin
            take_start = 1'b1;
            state_nxt  = FIRST;
          end else begin
            take_empty = 1'b1;
            state_nxt  = DONE;
          end
        end
      end
      FIRST: begin
        data_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (data_valid_i) begin
          load_first = 1'b1;
          state_nxt  = (len_q == CNT_W'(1)) ? DONE : SCAN;
        end
      end
      SCAN: begin
        data_ready_o = 1'b1;
        busy_o       = 1'b1;
        if (data_valid_i) begin
          load_scan = 1'b1;
          if (count_inc == len_q) begin
            state_nxt = DONE;
          end
        end
      end
      DONE: begin
        done_o    = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      mode_q   <= 1'b0;
      len_q    <= '0;
      count_q  <= '0;
      result_q <= '0;
      index_q  <= '0;
    end else begin
      if (take_start) begin
        mode_q  <= mode_i;
        len_q   <= len_i;
        count_q <= '0;
      end
      if (take_empty) begin
        result_q <= '0;
        index_q  <= '0;
        count_q  <= '0;
      end
      if (load_first) begin
        result_q <= data_i;
        index_q  <= '0;
        count_q  <= CNT_W'(1);
      end
      if (load_scan) begin
        count_q <= count_inc;
        if (replace) begin
          result_q <= data_i;
          index_q  <= count_q;
        end
      end
    end
  end

  assign result_o = result_q;
  assign index_o  = index_q;

endmodule

// File: tb/tb_minmax_scan.sv
// Testbench for minmax_scan: directed scenarios plus randomized searches
// checked against a behavioural first-occurrence max/min model.
module tb_minmax_scan;

  localparam int DW = 16;
  localparam int CW = 8;

  typedef logic [DW-1:0] sample_q_t[$];

  logic          clk_i;
  logic          reset_i;
  logic          start_i;
  logic          mode_i;
  logic [CW-1:0] len_i;
  logic [DW-1:0] data_i;
  logic          data_valid_i;
  logic          data_ready_o;
  logic [DW-1:0] result_o;
  logic [CW-1:0] index_o;
  logic          busy_o;
  logic          done_o;

  int checks = 0;
  int errors = 0;

  minmax_scan #(
    .DATA_W(DW),
    .CNT_W (CW)
  ) dut (
    .clk_i        (clk_i),
    .reset_i      (reset_i),
    .start_i      (start_i),
    .mode_i       (mode_i),
    .len_i        (len_i),
    .data_i       (data_i),
    .data_valid_i (data_valid_i),
    .data_ready_o (data_ready_o),
    .result_o     (result_o),
    .index_o      (index_o),
    .busy_o       (busy_o),
    .done_o       (done_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: first occurrence of the signed maximum (mode 0) or minimum (mode 1).
  function automatic void model(input bit mode, input sample_q_t s,
                                output logic [DW-1:0] res, output int idx);
    int best;
    best = $signed(s[0]);
    idx  = 0;
    for (int i = 1; i < s.size(); i++) begin
      if ((mode == 1'b0 && int'($signed(s[i])) > best) ||
          (mode == 1'b1 && int'($signed(s[i])) < best)) begin
        best = $signed(s[i]);
        idx  = i;
      end
    end
    res = DW'(best);
  endfunction

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // gap_n < 0 selects a random 0..2 idle cycles before each sample.
  // disturb drives stray starts with the opposite mode while busy.
  task automatic run_search(input string tag, input bit mode, input sample_q_t s,
                            input int gap_n, input bit disturb);
    logic [DW-1:0] exp_res;
    int            exp_idx;
    int            ng;
    model(mode, s, exp_res, exp_idx);
    start_i = 1'b1;
    mode_i  = mode;
    len_i   = CW'(s.size());
    step();
    start_i = 1'b0;
    check({tag, "_busy_start"}, 32'(busy_o), 32'd1);
    check({tag, "_ready_start"}, 32'(data_ready_o), 32'd1);
    for (int i = 0; i < s.size(); i++) begin
      ng = (gap_n < 0) ? $urandom_range(0, 2) : gap_n;
      for (int g = 0; g < ng; g++) begin
        data_valid_i = 1'b0;
        data_i       = DW'($urandom);
        if (disturb) begin
          start_i = 1'b1;
          mode_i  = ~mode;
          len_i   = CW'($urandom_range(0, 3));
        end
        step();
        start_i = 1'b0;
        check({tag, "_busy_gap"}, 32'(busy_o), 32'd1);
        check({tag, "_done_gap"}, 32'(done_o), 32'd0);
      end
      data_i       = s[i];
      data_valid_i = 1'b1;
      if (disturb && $urandom_range(0, 1) == 1) begin
        start_i = 1'b1;
        mode_i  = ~mode;
        len_i   = CW'($urandom_range(0, 3));
      end
      step();
      data_valid_i = 1'b0;
      start_i      = 1'b0;
      if (i < s.size() - 1) begin
        check({tag, "_done_early"}, 32'(done_o), 32'd0);
      end
    end
    check({tag, "_done"}, 32'(done_o), 32'd1);
    check({tag, "_busy_done"}, 32'(busy_o), 32'd0);
    check({tag, "_ready_done"}, 32'(data_ready_o), 32'd0);
    check({tag, "_result"}, 32'(result_o), 32'(exp_res));
    check({tag, "_index"}, 32'(index_o), 32'(exp_idx));
    step();
    check({tag, "_done_pulse"}, 32'(done_o), 32'd0);
    check({tag, "_result_hold"}, 32'(result_o), 32'(exp_res));
    check({tag, "_index_hold"}, 32'(index_o), 32'(exp_idx));
  endtask

  function automatic logic [DW-1:0] rand_sample();
    logic [DW-1:0] edge_vals[4];
    edge_vals[0] = 16'h8000;
    edge_vals[1] = 16'h7FFF;
    edge_vals[2] = 16'h0000;
    edge_vals[3] = 16'hFFFF;
    if ($urandom_range(0, 3) == 0) return edge_vals[$urandom_range(0, 3)];
    if ($urandom_range(0, 2) == 0) return DW'($urandom_range(0, 3));
    return DW'($urandom);
  endfunction

  initial begin
    sample_q_t s;
    int done_cnt;
    int ready_seen;
    int busy_seen;

    reset_i      = 1'b1;
    start_i      = 1'b0;
    mode_i       = 1'b0;
    len_i        = '0;
    data_i       = '0;
    data_valid_i = 1'b0;
    #1;
    check("rst_result", 32'(result_o), 32'd0);
    check("rst_index", 32'(index_o), 32'd0);
    check("rst_busy", 32'(busy_o), 32'd0);
    check("rst_done", 32'(done_o), 32'd0);
    check("rst_ready", 32'(data_ready_o), 32'd0);
    repeat (2) step();
    reset_i = 1'b0;
    step();

    // Max over 3,-7,12,12,5: first 12 wins.
    s = '{16'd3, 16'hFFF9, 16'd12, 16'd12, 16'd5};
    run_search("max5", 1'b0, s, 0, 1'b0);

    // Min across the full signed range.
    s = '{16'h7FFF, 16'h8000, 16'h0001, 16'hFFFF};
    run_search("min_ext", 1'b1, s, 0, 1'b0);

    // Max with two idle cycles between samples; tie on -1 keeps index 0.
    s = '{16'hFFFF, 16'hFFFF, 16'hFFFE};
    run_search("max_gap", 1'b0, s, 2, 1'b0);

    // Zero-length search: no samples taken, outputs cleared.
    start_i  = 1'b1;
    mode_i   = 1'b0;
    len_i    = '0;
    step();
    start_i    = 1'b0;
    done_cnt   = 0;
    ready_seen = 0;
    busy_seen  = 0;
    for (int k = 0; k < 4; k++) begin
      if (data_ready_o) ready_seen++;
      if (busy_o) busy_seen++;
      if (done_o) begin
        done_cnt++;
        check("len0_result", 32'(result_o), 32'd0);
        check("len0_index", 32'(index_o), 32'd0);
        check("len0_latency", 32'(k <= 1), 32'd1);
      end
      step();
    end
    check("len0_done_cnt", 32'(done_cnt), 32'd1);
    check("len0_ready", 32'(ready_seen), 32'd0);
    check("len0_busy", 32'(busy_seen), 32'd0);

    // Reset in the middle of a 4-sample search.
    start_i = 1'b1;
    mode_i  = 1'b0;
    len_i   = CW'(4);
    step();
    start_i = 1'b0;
    for (int i = 0; i < 2; i++) begin
      data_i       = DW'(100 + i);
      data_valid_i = 1'b1;
      step();
    end
    data_valid_i = 1'b0;
    check("mid_result_before", 32'(result_o), 32'd101);
    #2;
    reset_i = 1'b1;
    #1;
    check("mid_rst_result", 32'(result_o), 32'd0);
    check("mid_rst_index", 32'(index_o), 32'd0);
    check("mid_rst_busy", 32'(busy_o), 32'd0);
    check("mid_rst_ready", 32'(data_ready_o), 32'd0);
    done_cnt = 0;
    for (int k = 0; k < 3; k++) begin
      if (done_o) done_cnt++;
      step();
    end
    reset_i = 1'b0;
    for (int k = 0; k < 2; k++) begin
      if (done_o) done_cnt++;
      step();
    end
    check("mid_rst_no_done", 32'(done_cnt), 32'd0);
    s = '{16'd42};
    run_search("after_rst", 1'b0, s, 0, 1'b0);

    // Stray starts with the opposite mode during an active search.
    s = '{16'd5, 16'hFFF0, 16'd9, 16'd2, 16'h8000, 16'd9};
    run_search("disturb_max", 1'b0, s, 1, 1'b1);
    run_search("disturb_min", 1'b1, s, 1, 1'b1);

    // Longest length the counter supports.
    s = {};
    for (int i = 0; i < (1 << CW) - 1; i++) s.push_back(rand_sample());
    run_search("maxlen", 1'b0, s, 0, 1'b0);

    // Randomized searches.
    for (int t = 0; t < 25; t++) begin
      s = {};
      for (int i = 0; i < int'($urandom_range(1, 12)); i++) s.push_back(rand_sample());
      run_search("rand", 1'($urandom_range(0, 1)), s, -1, 1'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
